lp_mon: RTL and testbench
=========================

LP_MON -- requirements
Module: lp_mon

Interface
REQ-001 Parameter MX_LP, default 16, SHALL be the number of lamps observed.
REQ-002 Parameter KB_PT_1, default 5, SHALL be the kickback level (lit-lamp count) of the down phases.
REQ-003 Parameter CNT_W, default 8, SHALL be the width of each event counter.
REQ-004 Port list SHALL be exactly:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- smp_en  in  1  sample lp this cycle when high.
- lp  in  MX_LP  lamp vector under observation.
- clr_err  in  1  synchronous clear of err_flg.
- phase  out  3  current monitor phase (encoding in REQ-030).
- lvl  out  5  last accepted lit-lamp count, 0..16.
- err  out  1  one-cycle pulse on a detected violation.
- err_flg  out  1  sticky violation flag.
- err_code  out  2  cause of the most recent violation.
- seq_done  out  1  one-cycle pulse on a completed flash sequence.
- seq_cnt  out  CNT_W  completed-sequence count.
- kb_cnt  out  CNT_W  kickback count.

Function
REQ-005 A sample is legal-form only if lp equals 2^L-1 for some L in 0..16 (thermometer); L is the sample level.
REQ-006 Samples SHALL be taken only on rising clk edges with smp_en=1; with smp_en=0 all state and outputs other than pulses SHALL hold, and pulses SHALL be 0.
REQ-007 All outputs SHALL be registered; a response to the sample on edge k SHALL be visible after edge k (one-cycle latency).
REQ-008 Phases and transitions (L = new level, P = lvl):
- IDLE: L=0 stays; L=1 -> UP_A.
- UP_A: L=P+1; L=16 -> DN_A.
- DN_A: L=P-1; L=KB_PT_1 -> UP_B.
- UP_B: L=P+1; L=11 -> DN_B; L=12 stays UP_B, later L=16 -> DN_A and kb_cnt+1 (restart kickback).
- DN_B: L=P-1; L=KB_PT_1 -> next L=P+1 -> UP_B and kb_cnt+1; L=0 -> UP_C.
- UP_C: L=P+1; L=6 -> DN_C.
- DN_C: L=P-1; L=0 -> IDLE, seq_done=1, seq_cnt+1.
- ERR: see REQ-011.
REQ-009 Violations, err_code: 0 non-thermometer pattern; 1 |L-P| != 1 outside IDLE/ERR (includes stall L=P); 2 turnaround at a level not allowed by REQ-008; 3 up-step from IDLE to L>1.
REQ-010 On a violation in any phase but ERR: err=1 for one cycle, err_flg=1, err_code set, phase -> ERR, lvl updated to L if legal-form else held.
REQ-011 ERR: further violations SHALL NOT pulse err or change err_code; L=0 -> IDLE with no seq_done.
REQ-012 Violation priority SHALL be code 0 > 3 > 1 > 2; a violation suppresses seq_done and counter increments that cycle.
REQ-013 clr_err=1 SHALL clear err_flg unless a new violation is detected the same edge, in which case err_flg=1.
REQ-014 seq_cnt and kb_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-015 rst_n=0 SHALL asynchronously force phase=IDLE, lvl=0, err=0, err_flg=0, err_code=0, seq_done=0, seq_cnt=0, kb_cnt=0, including mid-sequence.
REQ-016 After rst_n release the first sample SHALL be judged against P=0 in IDLE.

Configuration
REQ-017 With macro LP_MON_CNT_EN defined, seq_cnt and kb_cnt SHALL count per REQ-008/REQ-014.
REQ-018 Without LP_MON_CNT_EN, counter registers SHALL be absent and seq_cnt, kb_cnt tied to 0; all other behaviour unchanged.

Structure
REQ-019 Package lp_mon_pkg SHALL hold the phase encoding (IDLE=0, UP_A=1, DN_A=2, UP_B=3, DN_B=4, UP_C=5, DN_C=6, ERR=7), err_code constants, and peak levels 16, 11, 6.
REQ-020 Sub-module lp_thermo_dec (combinational) SHALL map lp to level plus a legal-form flag.

Verification
REQ-021 Full nominal sequence 0,1..16..5..11..0..6..0 with smp_en=1 -> seq_done once, seq_cnt=1, kb_cnt=0, err never 1, phase ends IDLE.
REQ-022 DN_B reaches 5 then rises 6..11..0..6..0 -> kb_cnt=1, seq_cnt=1.
REQ-023 lp=16'h0005 in UP_A -> err pulse next edge, err_code=0, phase=ERR; then lp=0 -> IDLE, seq_done=0.
REQ-024 UP_A at 7 repeats 7 -> err_code=1; DN_A turning up at level 8 -> err_code=2.
REQ-025 rst_n low at level 9 in DN_A -> all outputs at reset values immediately; clr_err and violation same edge -> err_flg=1.

Source files
------------

// File: rtl/lp_mon_pkg.sv
// Shared definitions for the lamp-sequence monitor: phase encoding, violation codes and peak levels.
package lp_mon_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP_A = 3'd1,
        PH_DN_A = 3'd2,
        PH_UP_B = 3'd3,
        PH_DN_B = 3'd4,
        PH_UP_C = 3'd5,
        PH_DN_C = 3'd6,
        PH_ERR  = 3'd7
    } phase_t;

    localparam logic [1:0] EC_FORM = 2'd0;
    localparam logic [1:0] EC_STEP = 2'd1;
    localparam logic [1:0] EC_TURN = 2'd2;
    localparam logic [1:0] EC_JUMP = 2'd3;

    localparam logic [4:0] PK_A = 5'd16;
    localparam logic [4:0] PK_B = 5'd11;
    localparam logic [4:0] PK_C = 5'd6;

endpackage

// File: rtl/lp_thermo_dec.sv
// Thermometer decoder: lit-lamp count plus a flag that the pattern is contiguous from bit 0.
module lp_thermo_dec #(
    parameter int MX_LP = 16
) (
    input  logic [MX_LP-1:0] lp,
    output logic [4:0]       level,
    output logic             legal
);

    always_comb begin
        level = '0;
        for (int i = 0; i < MX_LP; i++) begin
            level = level + 5'(lp[i]);
        end
        // 2^L-1 is the only form where adding one clears every set bit
        legal = ((lp & (lp + MX_LP'(1))) == '0);
    end

endmodule

// File: rtl/lp_mon.sv
// Lamp flash-sequence monitor: tracks up/down phases, flags violations, counts sequences and kickbacks.
// Counters exist only when LP_MON_CNT_EN is defined; otherwise seq_cnt/kb_cnt read 0.
module lp_mon
    import lp_mon_pkg::*;
#(
    parameter int MX_LP   = 16,
    parameter int KB_PT_1 = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smp_en,
    input  logic [MX_LP-1:0] lp,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [4:0]       lvl,
    output logic             err,
    output logic             err_flg,
    output logic [1:0]       err_code,
    output logic             seq_done,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [CNT_W-1:0] kb_cnt
);

    localparam logic [4:0] KB_LVL = 5'(KB_PT_1);

    phase_t     phase_q, phase_d;
    logic [4:0] lvl_q, lvl_d;
    logic       err_q, flg_q, done_q;
    logic [1:0] code_q, code_v;
    logic       viol, done_c;
    logic [4:0] level;
    logic       legal, up, dn;

    lp_thermo_dec #(.MX_LP(MX_LP)) u_dec (
        .lp    (lp),
        .level (level),
        .legal (legal)
    );

    assign up = legal && (level == lvl_q + 5'd1);
    assign dn = legal && (lvl_q != 5'd0) && (level == lvl_q - 5'd1);

    always_comb begin
        phase_d = phase_q;
        lvl_d   = lvl_q;
        viol    = 1'b0;
        code_v  = EC_FORM;
        done_c  = 1'b0;
        if (phase_q == PH_ERR) begin
            if (legal) lvl_d = level;
            if (legal && level == 5'd0) phase_d = PH_IDLE;
        end else begin
            if (!legal) begin
                viol = 1'b1;
                code_v = EC_FORM;
            end else if (phase_q == PH_IDLE) begin
                if (level == 5'd1) phase_d = PH_UP_A;
                else if (level != 5'd0) begin
                    viol = 1'b1;
                    code_v = EC_JUMP;
                end
            end else if (!up && !dn) begin
                viol = 1'b1;
                code_v = EC_STEP;
            end else begin
                code_v = EC_TURN;
                case (phase_q)
                    PH_UP_A: if (dn) viol = 1'b1;
                             else if (level == PK_A) phase_d = PH_DN_A;
                    PH_DN_A: if (up) viol = 1'b1;
                             else if (level == KB_LVL) phase_d = PH_UP_B;
                    PH_UP_B: if (dn) viol = 1'b1;
                             else if (level == PK_B) phase_d = PH_DN_B;
                             else if (level == PK_A) phase_d = PH_DN_A;
                    // rising out of DN_B: kickback at the low point, or an extended rise past 11
                    PH_DN_B: if (up) begin
                                 if (lvl_q == KB_LVL || lvl_q == PK_B) phase_d = PH_UP_B;
                                 else viol = 1'b1;
                             end else if (level == 5'd0) phase_d = PH_UP_C;
                    PH_UP_C: if (dn) viol = 1'b1;
                             else if (level == PK_C) phase_d = PH_DN_C;
                    PH_DN_C: if (up) viol = 1'b1;
                             else if (level == 5'd0) begin
                                 phase_d = PH_IDLE;
                                 done_c = 1'b1;
                             end
                    default: ;
                endcase
            end
            if (viol) phase_d = PH_ERR;
            if (legal) lvl_d = level;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            lvl_q   <= '0;
            err_q   <= 1'b0;
            flg_q   <= 1'b0;
            code_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            err_q  <= smp_en & viol;
            done_q <= smp_en & done_c;
            if (smp_en) begin
                phase_q <= phase_d;
                lvl_q   <= lvl_d;
                if (viol) begin
                    code_q <= code_v;
                    flg_q  <= 1'b1;
                end else if (clr_err) begin
                    flg_q <= 1'b0;
                end
            end
        end
    end

`ifdef LP_MON_CNT_EN
    logic [CNT_W-1:0] seq_cnt_q, kb_cnt_q;
    logic             kb_inc;

    assign kb_inc = !viol && up &&
                    ((phase_q == PH_UP_B && level == PK_A) ||
                     (phase_q == PH_DN_B && lvl_q == KB_LVL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt_q <= '0;
            kb_cnt_q  <= '0;
        end else if (smp_en) begin
            if (done_c && seq_cnt_q != '1) seq_cnt_q <= seq_cnt_q + 1'b1;
            if (kb_inc && kb_cnt_q != '1)   kb_cnt_q  <= kb_cnt_q + 1'b1;
        end
    end

    assign seq_cnt = seq_cnt_q;
    assign kb_cnt  = kb_cnt_q;
`else
    assign seq_cnt = '0;
    assign kb_cnt  = '0;
`endif

    assign phase    = phase_q;
    assign lvl      = lvl_q;
    assign err      = err_q;
    assign err_flg  = flg_q;
    assign err_code = code_q;
    assign seq_done = done_q;

endmodule

// File: tb/tb_lp_mon.sv
// Self-checking bench for lp_mon: reference model feeds an expectation queue, DUT snapshots are compared per sample.
module tb_lp_mon;

    localparam int CW = 8;
`ifdef LP_MON_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    typedef struct packed {
        logic [2:0]    ph;
        logic [4:0]    lvl;
        logic          err;
        logic          flg;
        logic [1:0]    code;
        logic          done;
        logic [CW-1:0] sc;
        logic [CW-1:0] kb;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          smp_en = 1'b0;
    logic [15:0]   lp = '0;
    logic          clr_err = 1'b0;
    logic [2:0]    phase;
    logic [4:0]    lvl;
    logic          err, err_flg, seq_done;
    logic [1:0]    err_code;
    logic [CW-1:0] seq_cnt, kb_cnt;

    int tests = 0;
    int failed = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];
    snap_t e, o, dut_snap;

    int m_ph, m_lvl, m_code, m_sc, m_kb;
    bit m_err, m_flg, m_done;

    lp_mon #(.MX_LP(16), .KB_PT_1(5), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .smp_en(smp_en), .lp(lp), .clr_err(clr_err),
        .phase(phase), .lvl(lvl), .err(err), .err_flg(err_flg), .err_code(err_code),
        .seq_done(seq_done), .seq_cnt(seq_cnt), .kb_cnt(kb_cnt)
    );

    always #5 clk = ~clk;

    assign dut_snap = {phase, lvl, err, err_flg, err_code, seq_done, seq_cnt, kb_cnt};

    function automatic snap_t model_snap();
        snap_t s;
        s.ph = 3'(m_ph); s.lvl = 5'(m_lvl); s.err = m_err; s.flg = m_flg;
        s.code = 2'(m_code); s.done = m_done; s.sc = CW'(m_sc); s.kb = CW'(m_kb);
        return s;
    endfunction

    function automatic logic [15:0] therm(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_ph = 0; m_lvl = 0; m_code = 0; m_sc = 0; m_kb = 0;
        m_err = 0; m_flg = 0; m_done = 0;
    endtask

    task automatic model(input logic [15:0] v, input bit en, input bit clr);
        int  n, d, nph, c;
        bit  th, bad, kbi, dn_ok;
        n = 0; th = 1;
        for (int i = 0; i < 16; i++) if (v[i]) begin
            if (i != n) th = 0;
            n++;
        end
        m_err = 0; m_done = 0;
        if (!en) return;
        if (m_ph == 7) begin
            if (th) begin m_lvl = n; if (n == 0) m_ph = 0; end
            if (clr) m_flg = 0;
            return;
        end
        d = n - m_lvl; nph = m_ph; bad = 0; c = 0; kbi = 0; dn_ok = 0;
        if (!th) begin bad = 1; c = 0; end
        else if (m_ph == 0) begin
            if (n > 1) begin bad = 1; c = 3; end else if (n == 1) nph = 1;
        end else if (d != 1 && d != -1) begin bad = 1; c = 1; end
        else begin
            c = 2;
            case (m_ph)
                1: if (d == 1) begin if (n == 16) nph = 2; end else bad = 1;
                2: if (d == -1) begin if (n == 5) nph = 3; end else bad = 1;
                3: if (d == 1) begin
                       if (n == 11) nph = 4;
                       if (n == 16) begin nph = 2; kbi = 1; end
                   end else bad = 1;
                4: if (d == -1) begin if (n == 0) nph = 5; end
                   else if (m_lvl == 5) begin nph = 3; kbi = 1; end
                   else if (m_lvl == 11) nph = 3;
                   else bad = 1;
                5: if (d == 1) begin if (n == 6) nph = 6; end else bad = 1;
                6: if (d == -1) begin if (n == 0) begin nph = 0; dn_ok = 1; end end else bad = 1;
                default: ;
            endcase
        end
        if (bad) begin
            m_err = 1; m_flg = 1; m_code = c; m_ph = 7;
            if (th) m_lvl = n;
        end else begin
            m_ph = nph; m_lvl = n; m_done = dn_ok;
            if (clr) m_flg = 0;
            if (CNT_ON == 1) begin
                if (dn_ok && m_sc < 255) m_sc++;
                if (kbi && m_kb < 255) m_kb++;
            end
        end
    endtask

    task automatic step(input logic [15:0] v, input bit en = 1, input bit clr = 0);
        lp = v; smp_en = en; clr_err = clr;
        model(v, en, clr);
        exp_q.push_back(model_snap());
        @(posedge clk); #1;
        obs_q.push_back(dut_snap);
        smp_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic ramp(input int a, input int b);
        if (b > a) for (int k = a + 1; k <= b; k++) step(therm(k));
        else for (int k = a - 1; k >= b; k--) step(therm(k));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; smp_en = 1'b0; clr_err = 1'b0; lp = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_snap !== snap_t'(0)) begin
            failed++; $display("FAIL reset_state: got %h want %h", dut_snap, snap_t'(0));
        end
    endtask

    task automatic test_nominal();
        int dones = 0, errs = 0;
        do_reset();
        step(16'h0); ramp(0, 16); ramp(16, 5); ramp(5, 11); ramp(11, 0); ramp(0, 6); ramp(6, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            dones += int'(o.done); errs += int'(o.err);
            if (o !== e) begin failed++; $display("FAIL nominal_seq: got %h want %h", o, e); end
        end
        tests++;
        if (dones != 1 || errs != 0 || phase !== 3'd0 || seq_cnt !== CW'(CNT_ON) || kb_cnt !== '0) begin
            failed++;
            $display("FAIL nominal_summary: done=%0d err=%0d ph=%0d sc=%0d kb=%0d want 1 0 0 %0d 0",
                     dones, errs, phase, seq_cnt, kb_cnt, CNT_ON);
        end
    endtask

    task automatic test_kickback();
        do_reset();
        step(16'h0); ramp(0, 16); ramp(16, 5); ramp(5, 11); ramp(11, 5);
        ramp(5, 11); ramp(11, 0); ramp(0, 6); ramp(6, 0);
        // extended rise: 11 -> 12..16 re-enters DN_A with a kickback
        step(16'h0); ramp(0, 16); ramp(16, 5); ramp(5, 11); ramp(11, 16); ramp(16, 15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin failed++; $display("FAIL kickback_seq: got %h want %h", o, e); end
        end
        tests++;
        if (seq_cnt !== CW'(CNT_ON) || kb_cnt !== CW'(2 * CNT_ON) || phase !== 3'd2) begin
            failed++;
            $display("FAIL kickback_counts: sc=%0d kb=%0d ph=%0d want %0d %0d 2",
                     seq_cnt, kb_cnt, phase, CNT_ON, 2 * CNT_ON);
        end
    endtask

    task automatic test_violations();
        do_reset();
        ramp(0, 3); step(16'h0005);
        tests++;
        if (err !== 1'b1 || err_code !== 2'd0 || phase !== 3'd7 || lvl !== 5'd3) begin
            failed++; $display("FAIL form_err: err=%b code=%0d ph=%0d lvl=%0d want 1 0 7 3", err, err_code, phase, lvl);
        end
        step(16'h00f0); step(therm(4), 0); step(16'h0);
        tests++;
        if (phase !== 3'd0 || seq_done !== 1'b0 || err_code !== 2'd0 || err_flg !== 1'b1) begin
            failed++; $display("FAIL err_exit: ph=%0d done=%b code=%0d flg=%b want 0 0 0 1", phase, seq_done, err_code, err_flg);
        end
        ramp(0, 7); step(therm(7));
        tests++;
        if (err_code !== 2'd1 || err !== 1'b1) begin
            failed++; $display("FAIL stall_code: code=%0d err=%b want 1 1", err_code, err);
        end
        step(16'h0); ramp(0, 16); ramp(16, 8); step(therm(9));
        tests++;
        if (err_code !== 2'd2 || phase !== 3'd7) begin
            failed++; $display("FAIL turn_code: code=%0d ph=%0d want 2 7", err_code, phase);
        end
        step(16'h0); step(therm(3)); step(16'h0); step(16'h0009); step(16'h0);
        ramp(0, 4); step(therm(6)); step(16'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin failed++; $display("FAIL violation_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_and_clr();
        do_reset();
        step(16'h0); ramp(0, 16); ramp(16, 9);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if (dut_snap !== snap_t'(0)) begin
            failed++; $display("FAIL async_reset: got %h want %h", dut_snap, snap_t'(0));
        end
        @(negedge clk); rst_n = 1'b1; model_reset();
        step(16'h0); step(therm(3), 1, 1);
        tests++;
        if (err_flg !== 1'b1 || err_code !== 2'd3) begin
            failed++; $display("FAIL clr_vs_viol: flg=%b code=%0d want 1 3", err_flg, err_code);
        end
        step(16'h0); ramp(0, 2); step(therm(3), 1, 1);
        tests++;
        if (err_flg !== 1'b0) begin
            failed++; $display("FAIL clr_flag: flg=%b want 0", err_flg);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin failed++; $display("FAIL reset_clr_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int s = 0; s < 260; s++) begin
            step(16'h0); ramp(0, 16); ramp(16, 5); ramp(5, 11); ramp(11, 0); ramp(0, 6); ramp(6, 0);
        end
        step(16'h0); ramp(0, 16); ramp(16, 5); ramp(5, 11);
        for (int s = 0; s < 260; s++) begin ramp(11, 5); ramp(5, 11); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin failed++; $display("FAIL saturation_seq: got %h want %h", o, e); end
        end
        tests++;
        if (seq_cnt !== CW'(255 * CNT_ON) || kb_cnt !== CW'(255 * CNT_ON)) begin
            failed++; $display("FAIL saturation: sc=%0d kb=%0d want %0d", seq_cnt, kb_cnt, 255 * CNT_ON);
        end
    endtask

    task automatic test_back_to_back();
        int r, nl;
        logic [15:0] v;
        do_reset();
        for (int s = 0; s < 3000; s++) begin
            r = int'($urandom_range(0, 39));
            if (r < 18) nl = m_lvl + 1;
            else if (r < 36) nl = m_lvl - 1;
            else if (r < 37) nl = m_lvl;
            else nl = 0;
            if (m_ph == 7 && $urandom_range(0, 3) == 0) nl = 0;
            if (nl < 0) nl = 0;
            if (nl > 16) nl = 16;
            v = therm(nl);
            if (r == 39) v = 16'($urandom_range(0, 65535)) | 16'h0102;
            step(v, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o !== e) begin failed++; $display("FAIL random_walk: got %h want %h", o, e); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_kickback();
        test_violations();
        test_reset_mid_and_clr();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
